// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data (load/store)
// requesters through an issue/wait/respond FSM with fixed memory latency.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state;
  owner_t            owner;
  logic              wr_q;
  logic              starve;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_data;
  logic              done;

  // Data normally wins a tie; a pending starve flag hands the tie to fetch.
  assign grant_data = d_req && (!if_req || !starve);

  // Last latency cycle of the access: memory data is valid at its closing edge.
  assign done = ((state == ISSUE) && (MEM_LAT == 1)) ||
                ((state == WAIT) && (cnt == 4'd1));

  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_FETCH;
      wr_q      <= 1'b0;
      starve    <= 1'b0;
      cnt       <= 4'd0;
      rdata_q   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_wr   <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            mem_wr   <= grant_data && d_wr;
            wr_q     <= grant_data && d_wr;
            owner    <= grant_data ? OWN_DATA : OWN_FETCH;
            mem_addr <= grant_data ? d_addr : if_addr;
            if (grant_data) begin
              mem_wdata <= d_wdata;
              if (if_req) starve <= 1'b1;
            end else begin
              starve <= 1'b0;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Completion overrides the plain state advance above.
      if (done) begin
        state <= RESP;
        if (!wr_q) rdata_q <= mem_rdata;
        if (owner == OWN_DATA) d_valid  <= 1'b1;
        else                   if_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=4, one at MEM_LAT=1,
// each behind a small latency-accurate memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (MEM_LAT=4)
  logic        if_req_a = 0, d_req_a = 0, d_wr_a = 0;
  logic [15:0] if_addr_a = 0, d_addr_a = 0, d_wdata_a = 0;
  logic [15:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        if_valid_a, d_valid_a, mem_en_a, mem_wr_a, busy_a;

  // Instance B (MEM_LAT=1)
  logic        if_req_b = 0, d_req_b = 0, d_wr_b = 0;
  logic [15:0] if_addr_b = 0, d_addr_b = 0, d_wdata_b = 0;
  logic [15:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        if_valid_b, d_valid_b, mem_en_b, mem_wr_b, busy_b;

  logic [15:0] mem [0:1023];
  int          k_reg = 0;
  int          k_now;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a), .if_valid(if_valid_a),
    .d_req(d_req_a), .d_wr(d_wr_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_rdata(d_rdata_a), .d_valid(d_valid_a),
    .mem_en(mem_en_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_valid(if_valid_b),
    .d_req(d_req_b), .d_wr(d_wr_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_rdata(d_rdata_b), .d_valid(d_valid_b),
    .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // Memory A: read data is only valid in latency cycle 4 (ISSUE = cycle 1).
  always @(posedge clk) begin
    if (mem_en_a)        k_reg <= 2;
    else if (k_reg != 0) k_reg <= (k_reg >= 4) ? 0 : k_reg + 1;
  end
  assign k_now       = mem_en_a ? 1 : k_reg;
  assign mem_rdata_a = (k_now == 4) ? mem[mem_addr_a[9:0]] : 16'hDEAD;
  assign mem_rdata_b = mem_en_b ? mem[mem_addr_b[9:0]] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          last_f;
    int          nseq;
    logic [3:0]  seq;
    int          fgap;
    logic        saw_valid;

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h010] = 16'hA1B2;
    mem[10'h020] = 16'h5555;
    mem[10'h030] = 16'h3C3C;
    mem[10'h040] = 16'h00FF;

    // Reset state
    #1;
    chk("rst_mem_en", mem_en_a, 1'b0);
    chk("rst_mem_wr", mem_wr_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valids", {if_valid_a, d_valid_a}, 2'b00);
    chk("rst_mem_addr", mem_addr_a, 16'h0000);
    chk("rst_rdata", if_rdata_a, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: fetch only, 0x0010 -> 0xA1B2, valid in T+5
    @(negedge clk);
    if_req_a = 1; if_addr_a = 16'h0010;
    @(negedge clk);
    chk("t1_issue_en", mem_en_a, 1'b1);
    chk("t1_issue_wr", mem_wr_a, 1'b0);
    chk("t1_issue_addr", mem_addr_a, 16'h0010);
    chk("t1_busy", busy_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_wait_en", mem_en_a, 1'b0);
      chk("t1_wait_valid", {if_valid_a, d_valid_a}, 2'b00);
      chk("t1_wait_addr", mem_addr_a, 16'h0010);
    end
    @(negedge clk);
    chk("t1_if_valid", if_valid_a, 1'b1);
    chk("t1_if_rdata", if_rdata_a, 16'hA1B2);
    chk("t1_d_valid", d_valid_a, 1'b0);
    if_req_a = 0;
    @(negedge clk);
    chk("t1_valid_pulse", if_valid_a, 1'b0);
    chk("t1_idle_busy", busy_a, 1'b0);

    // Test 2: store 0x1234 to 0x0200
    d_req_a = 1; d_wr_a = 1; d_addr_a = 16'h0200; d_wdata_a = 16'h1234;
    @(negedge clk);
    chk("t2_en_wr", {mem_en_a, mem_wr_a}, 2'b11);
    chk("t2_addr", mem_addr_a, 16'h0200);
    chk("t2_wdata", mem_wdata_a, 16'h1234);
    @(negedge clk);
    chk("t2_en_once", {mem_en_a, mem_wr_a}, 2'b00);
    chk("t2_wdata_held", mem_wdata_a, 16'h1234);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t2_d_valid", d_valid_a, 1'b1);
    chk("t2_if_valid", if_valid_a, 1'b0);
    chk("t2_rdata_kept", d_rdata_a, 16'hA1B2);
    d_req_a = 0; d_wr_a = 0;
    @(negedge clk);
    chk("t2_valid_pulse", d_valid_a, 1'b0);

    // Test 3: simultaneous requests, data first then fetch
    if_req_a = 1; if_addr_a = 16'h0020;
    d_req_a = 1; d_wr_a = 0; d_addr_a = 16'h0030;
    @(negedge clk);
    chk("t3_first_addr", mem_addr_a, 16'h0030);
    chk("t3_starve_set", u_a.starve, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t3_d_valid", {d_valid_a, if_valid_a}, 2'b10);
    chk("t3_d_rdata", d_rdata_a, 16'h3C3C);
    d_req_a = 0;
    @(negedge clk);
    chk("t3_resp_idle", busy_a, 1'b0);
    @(negedge clk);
    chk("t3_second_en", mem_en_a, 1'b1);
    chk("t3_second_addr", mem_addr_a, 16'h0020);
    chk("t3_starve_clr", u_a.starve, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t3_if_valid", {d_valid_a, if_valid_a}, 2'b01);
    chk("t3_if_rdata", if_rdata_a, 16'h5555);
    if_req_a = 0;
    @(negedge clk);

    // Test 4: both held high -> D,F,D,F with fetch every 12 cycles
    if_req_a = 1; if_addr_a = 16'h0010;
    d_req_a = 1; d_wr_a = 0; d_addr_a = 16'h0040;
    nseq = 0; seq = '0; last_f = -1; fgap = 0;
    for (int c = 0; c < 60 && nseq < 4; c++) begin
      @(negedge clk);
      if (d_valid_a || if_valid_a) begin
        seq[nseq] = if_valid_a;
        nseq++;
        if (if_valid_a) begin
          if (last_f >= 0) fgap = c - last_f;
          last_f = c;
        end
      end
    end
    if_req_a = 0; d_req_a = 0;
    chk("t4_count", nseq, 4);
    chk("t4_order", seq, 4'b1010);
    chk("t4_fetch_gap", fgap, 12);
    repeat (2) @(negedge clk);
    chk("t4_idle", busy_a, 1'b0);

    // Test 5: async reset in WAIT of a load
    d_req_a = 1; d_wr_a = 0; d_addr_a = 16'h0030;
    @(negedge clk);
    chk("t5_issue", mem_en_a, 1'b1);
    @(negedge clk);
    chk("t5_in_wait", {busy_a, mem_en_a}, 2'b10);
    rst_n = 0; d_req_a = 0;
    #1;
    chk("t5_rst_busy", busy_a, 1'b0);
    chk("t5_rst_addr", mem_addr_a, 16'h0000);
    chk("t5_rst_rdata", d_rdata_a, 16'h0000);
    chk("t5_rst_strobes", {mem_en_a, mem_wr_a, if_valid_a, d_valid_a}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1;
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_valid_a || if_valid_a || busy_a) saw_valid = 1;
    end
    chk("t5_no_pulse", saw_valid, 1'b0);
    if_req_a = 1; if_addr_a = 16'h0010;
    @(negedge clk);
    chk("t5_new_issue", mem_addr_a, 16'h0010);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t5_new_valid", if_valid_a, 1'b1);
    chk("t5_new_rdata", if_rdata_a, 16'hA1B2);
    if_req_a = 0;
    @(negedge clk);

    // Test 6: MEM_LAT=1 load of 0x00FF, valid in T+2
    d_req_b = 1; d_wr_b = 0; d_addr_b = 16'h0040;
    @(negedge clk);
    chk("t6_issue", {mem_en_b, mem_wr_b, d_valid_b}, 3'b100);
    chk("t6_addr", mem_addr_b, 16'h0040);
    @(negedge clk);
    chk("t6_d_valid", {d_valid_b, if_valid_b}, 2'b10);
    chk("t6_d_rdata", d_rdata_b, 16'h00FF);
    d_req_b = 0;
    @(negedge clk);
    chk("t6_valid_pulse", d_valid_b, 1'b0);
    @(negedge clk);
    chk("t6_idle", {busy_b, mem_en_b}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
